nv_csa_acc_seq: RTL
===================

Name: nv_csa_acc_seq

Overview:
- Sequencer that time-shares one carry-save (CSA) compressor tree across a multi-beat operand stream.
- Each beat carries NUM_IN operands. They are compressed together with the running carry-save accumulator pair into a new pair.
- On the last beat of a packet, the pair is resolved by one carry-propagate add and the result is presented on a valid/ready output.
- Sits between an operand producer (e.g. partial-product or bias stage) and the downstream consumer in the MAC datapath.

Parameters:
- NUM_IN, 4, operands per input beat (>=1).
- WIDTH, 24, operand / accumulator / result width in bits.
- CNT_W, 8, width of the beat counter.

Ports:
- nvdla_core_clk  input  1  core clock; all state on rising edge.
- nvdla_core_rstn  input  1  asynchronous active-low reset.
- in_pvld  input  1  input beat valid.
- in_prdy  output  1  input beat ready.
- in_data  input  NUM_IN*WIDTH  operand k at bits [k*WIDTH +: WIDTH].
- in_last  input  1  marks final beat of packet; qualified by in_pvld.
- out_pvld  output  1  result valid.
- out_prdy  input  1  result ready.
- out_data  output  WIDTH  packet sum modulo 2^WIDTH.
- out_beats  output  CNT_W  beats accepted in packet, saturating.
- out_ovf  output  1  beat counter saturated during packet.

Behaviour:
- Handshakes: input accepted when in_pvld & in_prdy; output transferred when out_pvld & out_prdy.
- FSM states ACC, RES, OUT. Reset state ACC.
- ACC:
  - in_prdy = 1.
  - On accept: tree inputs = NUM_IN operands + acc_sum + acc_carry (NUM_IN+2 inputs); registered tree outputs become the new acc_sum/acc_carry.
  - beat_cnt increments, saturating at 2^CNT_W-1; ovf_r sets when an increment is attempted at saturation.
  - If in_last, go to RES.
- RES:
  - in_prdy = 0.
  - out_data_r <= acc_sum + acc_carry (WIDTH-bit add, carry-out discarded).
  - out_beats_r <= beat_cnt; out_ovf <= ovf_r.
  - Clear acc_sum, acc_carry, beat_cnt, ovf_r to 0. Go to OUT.
- OUT:
  - out_pvld = 1; in_prdy = 0.
  - out_data, out_beats and out_ovf are held stable until transfer.
  - On out_prdy, go to ACC.
  - No packet overlap: the next packet's first beat can be accepted at the earliest the cycle after the output transfer.
- Latency: last beat accepted at cycle T -> out_pvld high at T+2. Minimum packet-to-packet period is 3 cycles for a 1-beat packet.
- Arithmetic:
  - All arithmetic is modulo 2^WIDTH; two's-complement operands wrap naturally.
  - Tree carry outputs are truncated to WIDTH bits (shifted-out MSB dropped).
- in_data and in_last are ignored when not accepted. in_pvld without in_last simply continues the packet.
- Reset (any time, including mid-packet or in OUT):
  - State = ACC; acc_sum, acc_carry, beat_cnt, ovf_r cleared.
  - out_pvld = 0, out_data = 0, out_beats = 0, out_ovf = 0.
  - Partially accumulated packet is discarded.
- in_prdy is a pure decode of state; no combinational path from out_prdy to in_prdy.

Decomposition:
- Shared package: state encodings (ACC=2'd0, RES=2'd1, OUT=2'd2) and the default WIDTH/NUM_IN/CNT_W constants for the MAC datapath.
- One natural sub-module: the codebase CSA compressor tree NV_DW02_tree, instantiated with num_inputs = NUM_IN+2, input_width = WIDTH.
- The FSM, accumulator registers, counter and final adder stay in nv_csa_acc_seq.

Test Plan:
- Single beat, {1,2,3,4}, in_last=1 at cycle T, out_prdy=1 -> out_pvld at T+2, out_data=10, out_beats=1, out_ovf=0; in_prdy back to 1 at T+3.
- Three beats {5,6,7,8}, {100,0,0,0}, {0,0,0,1}+last, in_pvld every cycle -> in_prdy stays 1 through the 3 beats; out_data=127, out_beats=3.
- Wrap: {0xFFFFFF,0x000001,0,0}+last -> out_data=0x000000. Then {0xFFFFFF,0xFFFFFF,0,0}+last -> out_data=0xFFFFFE.
- Backpressure: out_prdy=0 for 5 cycles after out_pvld -> out_data/out_beats stable, in_prdy=0 throughout; a new beat offered early is accepted the cycle after the out_prdy=1 transfer.
- Reset mid-packet: accept {7,0,0,0}, {9,0,0,0} (no last), pulse nvdla_core_rstn low -> all outputs 0, in_prdy=1; next packet {1,0,0,0}+last -> out_data=1, out_beats=1.
- Saturation, CNT_W=2: five beats {1,0,0,0}, last on 5th -> out_data=5, out_beats=3, out_ovf=1; following 1-beat packet -> out_ovf=0.

Source files
------------

// File: rtl/nv_csa_acc_seq_pkg.sv
// -----------------------------------------------------------------------------
// nv_csa_acc_seq_pkg
//
// Shared definitions for the carry-save accumulation sequencer:
//   - state_e      : sequencer states (ACC accumulate, RES resolve, OUT present)
//   - NV_NUM_IN    : default operands per input beat for the MAC datapath
//   - NV_WIDTH     : default operand / accumulator / result width
//   - NV_CNT_W     : default beat counter width
// -----------------------------------------------------------------------------
package nv_csa_acc_seq_pkg;

    localparam int NV_NUM_IN = 4;
    localparam int NV_WIDTH  = 24;
    localparam int NV_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_RES = 2'd1,
        ST_OUT = 2'd2
    } state_e;

endpackage : nv_csa_acc_seq_pkg

// File: rtl/nv_csa_acc_seq_tree.sv
// -----------------------------------------------------------------------------
// NV_DW02_tree
//
// Carry-save compressor: reduces num_inputs operands of input_width bits to a
// sum/carry pair such that OUT0 + OUT1 == sum(INPUT) modulo 2^input_width.
// Purely combinational.
//
// Ports:
//   INPUT  in   num_inputs*input_width  operand k at [k*input_width +: input_width]
//   OUT0   out  input_width             sum vector
//   OUT1   out  input_width             carry vector (already shifted, MSB dropped)
//
// The reduction is a chain of 3:2 counters folding one operand per stage into
// the running pair. For the handful of inputs used by the sequencer the chain
// depth is small and the structure maps cleanly onto full-adder rows.
// -----------------------------------------------------------------------------
module NV_DW02_tree #(
    parameter int num_inputs  = 6,
    parameter int input_width = 24
) (
    input  logic [num_inputs*input_width-1:0] INPUT,
    output logic [input_width-1:0]            OUT0,
    output logic [input_width-1:0]            OUT1
);

    logic [input_width-1:0] s_v;
    logic [input_width-1:0] c_v;
    logic [input_width-1:0] a_v;
    logic [input_width-1:0] maj_v;

    // NOTE: blocking assignments are deliberate here -- each loop iteration
    // must see the pair produced by the previous 3:2 stage within the same
    // evaluation, which is exactly what combinational logic needs.
    always_comb begin
        s_v   = INPUT[0 +: input_width];
        c_v   = '0;
        a_v   = '0;
        maj_v = '0;
        for (int k = 1; k < num_inputs; k++) begin
            a_v   = INPUT[k*input_width +: input_width];
            maj_v = (s_v & c_v) | (s_v & a_v) | (c_v & a_v);
            s_v   = s_v ^ c_v ^ a_v;
            // Carry moves one bit up; the bit shifted past the MSB is dropped
            // because all arithmetic is modulo 2^input_width.
            c_v   = maj_v << 1;
        end
        OUT0 = s_v;
        OUT1 = c_v;
    end

endmodule : NV_DW02_tree

// File: rtl/nv_csa_acc_seq.sv
// -----------------------------------------------------------------------------
// nv_csa_acc_seq
//
// Time-shares one carry-save compressor tree across a multi-beat operand
// stream. Every accepted beat folds its NUM_IN operands into a running
// carry-save pair; on the packet's last beat the pair is resolved with one
// carry-propagate add and presented on a valid/ready output.
//
// Ports:
//   nvdla_core_clk   in   1              core clock, rising edge
//   nvdla_core_rstn  in   1              asynchronous active-low reset
//   in_pvld          in   1              input beat valid
//   in_prdy          out  1              input beat ready (decode of state)
//   in_data          in   NUM_IN*WIDTH   operand k at [k*WIDTH +: WIDTH]
//   in_last          in   1              final beat of packet
//   out_pvld         out  1              result valid
//   out_prdy         in   1              result ready
//   out_data         out  WIDTH          packet sum modulo 2^WIDTH
//   out_beats        out  CNT_W          beats accepted, saturating
//   out_ovf          out  1              beat counter saturated in packet
//
// Flow: ACC (accept beats) -> RES (resolve pair, clear accumulator)
//       -> OUT (hold result until transfer) -> ACC.
// Last beat accepted in cycle T gives out_pvld in cycle T+2.
// -----------------------------------------------------------------------------
module nv_csa_acc_seq
    import nv_csa_acc_seq_pkg::*;
#(
    parameter int NUM_IN = NV_NUM_IN,
    parameter int WIDTH  = NV_WIDTH,
    parameter int CNT_W  = NV_CNT_W
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    input  logic                    in_pvld,
    output logic                    in_prdy,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_pvld,
    input  logic                    out_prdy,
    output logic [WIDTH-1:0]        out_data,
    output logic [CNT_W-1:0]        out_beats,
    output logic                    out_ovf
);

    localparam int                 TREE_N  = NUM_IN + 2;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   acc_sum_q,   acc_sum_d;
    logic [WIDTH-1:0]   acc_carry_q, acc_carry_d;
    logic [CNT_W-1:0]   beat_cnt_q,  beat_cnt_d;
    logic               ovf_q,       ovf_d;
    logic [WIDTH-1:0]   out_data_q,  out_data_d;
    logic [CNT_W-1:0]   out_beats_q, out_beats_d;
    logic               out_ovf_q,   out_ovf_d;

    logic [TREE_N*WIDTH-1:0] tree_in;
    logic [WIDTH-1:0]        tree_sum;
    logic [WIDTH-1:0]        tree_carry;

    // The running pair rides along as the two top tree inputs, so one tree
    // pass both adds the new operands and keeps the result redundant.
    assign tree_in = {acc_carry_q, acc_sum_q, in_data};

    NV_DW02_tree #(
        .num_inputs  (TREE_N),
        .input_width (WIDTH)
    ) u_tree (
        .INPUT (tree_in),
        .OUT0  (tree_sum),
        .OUT1  (tree_carry)
    );

    // NOTE: every signal this block drives gets a default before the case
    // statement; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        acc_sum_d   = acc_sum_q;
        acc_carry_d = acc_carry_q;
        beat_cnt_d  = beat_cnt_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;
        in_prdy     = 1'b0;
        out_pvld    = 1'b0;

        unique case (state_q)
            ST_ACC: begin
                in_prdy = 1'b1;
                if (in_pvld) begin
                    acc_sum_d   = tree_sum;
                    acc_carry_d = tree_carry;
                    // Counter sticks at its maximum; the overflow flag records
                    // that at least one beat went uncounted.
                    if (beat_cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d = ST_RES;
                    end
                end
            end

            ST_RES: begin
                // Single carry-propagate add; carry-out falls off the top.
                out_data_d  = acc_sum_q + acc_carry_q;
                out_beats_d = beat_cnt_q;
                out_ovf_d   = ovf_q;
                acc_sum_d   = '0;
                acc_carry_d = '0;
                beat_cnt_d  = '0;
                ovf_d       = 1'b0;
                state_d     = ST_OUT;
            end

            ST_OUT: begin
                out_pvld = 1'b1;
                if (out_prdy) begin
                    state_d = ST_ACC;
                end
            end

            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q     <= ST_ACC;
            acc_sum_q   <= '0;
            acc_carry_q <= '0;
            beat_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_sum_q   <= acc_sum_d;
            acc_carry_q <= acc_carry_d;
            beat_cnt_q  <= beat_cnt_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;
    assign out_ovf   = out_ovf_q;

endmodule : nv_csa_acc_seq
